// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch sequencer. Owns the program counter, fetches one word at a
// time from an instruction ROM over a req/ack handshake (any ROM latency,
// including zero-wait), and presents the fetched word to decode over a
// valid/ready handshake. Taken branches redirect to PC + ImmOp; a flush from a
// later stage redirects to flush_pc. A misaligned redirect target halts the
// controller with a sticky fault until reset.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset (0 = in reset)
//   ImmOp       sign-extended branch offset, sampled with a consume
//   PCsrc       1 = the instruction being consumed is a taken branch
//   flush       one-cycle redirect request (highest priority)
//   flush_pc    redirect target, valid with flush
//   mem_req     ROM request, held until mem_ack
//   mem_addr    ROM byte address
//   mem_ack     ROM completion, mem_rdata valid in the same cycle
//   mem_rdata   ROM read data
//   inst_valid  inst/PC hold an instruction for decode
//   inst_ready  decode accepts the instruction
//   inst        instruction word
//   PC          byte address of inst
//   fault       sticky misaligned-target fault
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ImmOp,
  input  logic        PCsrc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] PC,
  output logic        fault
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // first cycle after reset release
    ST_FETCH = 3'd1,  // request outstanding for pc_reg
    ST_OUT   = 3'd2,  // instruction presented to decode
    ST_DROP  = 3'd3,  // request outstanding, its data will be discarded
    ST_HALT  = 3'd4   // misaligned target seen; only reset leaves
  } state_t;

  state_t      state_reg, state_next;

  // pc_reg: address of the next fetch (or the faulting address in HALT).
  logic [31:0] pc_reg, pc_next;
  // Instruction register and the address it was fetched from.
  logic [31:0] inst_reg, inst_next;
  logic [31:0] pc_out_reg, pc_out_next;
  // Address of the request that is being dropped. A flush moves pc_reg to
  // the new target immediately, but the ROM request already in flight must
  // keep its address stable until it is acknowledged, so the old address is
  // parked here and drives mem_addr while in DROP.
  logic [31:0] drop_addr_reg, drop_addr_next;

  logic        consume;
  logic [31:0] branch_target;
  logic [31:0] seq_pc;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Plain 32-bit truncating arithmetic: wrap-around is silent.
  assign branch_target = pc_out_reg + ImmOp;
  assign seq_pc        = pc_reg + 32'(PC_STEP);
  assign consume       = (state_reg == ST_OUT) && inst_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers, updated alongside the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg        <= RESET_PC;
      inst_reg      <= '0;
      pc_out_reg    <= RESET_PC;
      drop_addr_reg <= RESET_PC;
    end else begin
      pc_reg        <= pc_next;
      inst_reg      <= inst_next;
      pc_out_reg    <= pc_out_next;
      drop_addr_reg <= drop_addr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    inst_next      = inst_reg;
    pc_out_next    = pc_out_reg;
    drop_addr_next = drop_addr_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (flush) begin
          pc_next    = flush_pc;
          state_next = misaligned(flush_pc) ? ST_HALT : ST_FETCH;
        end else begin
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (flush) begin
          pc_next = flush_pc;
          if (mem_ack) begin
            // Request completes this cycle: its data is simply not latched.
            state_next = misaligned(flush_pc) ? ST_HALT : ST_FETCH;
          end else begin
            // Request cannot be withdrawn; wait it out in DROP at the old
            // address. Misalignment of the new target is judged on exit.
            drop_addr_next = pc_reg;
            state_next     = ST_DROP;
          end
        end else if (mem_ack) begin
          inst_next   = mem_rdata;
          pc_out_next = pc_reg;
          pc_next     = seq_pc;
          state_next  = ST_OUT;
        end
      end

      ST_OUT: begin
        // flush outranks a simultaneous consume; no branch is applied then.
        if (flush) begin
          pc_next    = flush_pc;
          state_next = misaligned(flush_pc) ? ST_HALT : ST_FETCH;
        end else if (consume) begin
          if (PCsrc) begin
            pc_next    = branch_target;
            state_next = misaligned(branch_target) ? ST_HALT : ST_FETCH;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end

      ST_DROP: begin
        if (flush) begin
          pc_next = flush_pc;
        end
        // Decide on the redirected pc (including a same-cycle flush).
        if (mem_ack) begin
          state_next = misaligned(pc_next) ? ST_HALT : ST_FETCH;
        end
      end

      ST_HALT: begin
        state_next = ST_HALT;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = pc_reg;
    inst_valid = 1'b0;
    fault      = 1'b0;

    unique case (state_reg)
      ST_FETCH: begin
        mem_req = 1'b1;
      end
      ST_DROP: begin
        mem_req  = 1'b1;
        mem_addr = drop_addr_reg;
      end
      ST_OUT: begin
        inst_valid = 1'b1;
      end
      ST_HALT: begin
        fault = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign inst = inst_reg;
  assign PC   = pc_out_reg;

endmodule
